// File: rtl/alu_seq_pkg.sv
// Shared codes and types for the ALU command sequencer.
// Command opcodes, ALU function selects and the sequencer state encoding.
package alu_seq_pkg;

   localparam int WIDTH = 16;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   localparam logic [1:0] ALUOP_AND = 2'b00;
   localparam logic [1:0] ALUOP_OR  = 2'b01;
   localparam logic [1:0] ALUOP_ADD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_MUL;
   endfunction

endpackage

// File: rtl/alu_seq_mul_dp.sv
// Shift-add multiply datapath: high accumulator P, multiplier Q, multiplicand M.
// One ALU add per step; the carry-out becomes the new top bit of P.
module alu_seq_mul_dp #(
   parameter int WIDTH     = 16,
   parameter int MUL_STEPS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] load_a,
   input  logic [WIDTH-1:0] load_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             done,
   output logic [WIDTH-1:0] p_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   localparam int CNT_W = $clog2(MUL_STEPS) + 1;

   logic [WIDTH-1:0] p, q, m;
   logic [CNT_W-1:0] cnt;

   assign alu_a = p;
   assign alu_b = q[0] ? m : '0;
   assign done  = (cnt == CNT_W'(MUL_STEPS - 1));

   // {P,Q} <= {carry, sum, Q} >> 1
   assign p_nxt = {alu_carry, alu_result[WIDTH-1:1]};
   assign q_nxt = {alu_result[0], q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p   <= '0;
         q   <= '0;
         m   <= '0;
         cnt <= '0;
      end else if (load) begin
         p   <= '0;
         q   <= load_b;
         m   <= load_a;
         cnt <= '0;
      end else if (step) begin
         p   <= p_nxt;
         q   <= q_nxt;
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle command front end for an external 16-bit ripple-carry ALU.
// Builds SUB/SLT/MUL from the ALU's AND/OR/ADD primitives and returns a registered response.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MUL_STEPS = 16
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             CmdValid,
   output logic             CmdReady,
   input  logic [2:0]       CmdOp,
   input  logic [WIDTH-1:0] CmdA,
   input  logic [WIDTH-1:0] CmdB,
   output logic             RspValid,
   input  logic             RspReady,
   output logic [WIDTH-1:0] RspResult,
   output logic [WIDTH-1:0] RspHigh,
   output logic             RspZero,
   output logic             RspCarry,
   output logic             RspError,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic [1:0]       AluOp,
   output logic             AluBNegate,
   input  logic [WIDTH-1:0] AluResult,
   input  logic             AluZero,
   input  logic             AluCarryOut
);

   state_e           state, state_nxt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] res_q, high_q;
   logic             zero_q, carry_q, err_q;

   logic             accept, mul_load, mul_done;
   logic [WIDTH-1:0] mul_a, mul_b, mul_p_nxt, mul_q_nxt;
   logic             slt_ovf;
   logic [WIDTH-1:0] exec_res;
   logic             exec_zero, exec_carry;

   assign accept   = CmdValid && (state == ST_IDLE);
   assign mul_load = accept && (CmdOp == OP_MUL);

   alu_seq_mul_dp #(
      .WIDTH     (WIDTH),
      .MUL_STEPS (MUL_STEPS)
   ) u_mul_dp (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .load       (mul_load),
      .step       (state == ST_MUL),
      .load_a     (CmdA),
      .load_b     (CmdB),
      .alu_result (AluResult),
      .alu_carry  (AluCarryOut),
      .alu_a      (mul_a),
      .alu_b      (mul_b),
      .done       (mul_done),
      .p_nxt      (mul_p_nxt),
      .q_nxt      (mul_q_nxt)
   );

   // SLT from A + ~B + 1: sign of the difference corrected for signed overflow
   assign slt_ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (AluResult[WIDTH-1] != a_q[WIDTH-1]);
   assign exec_res   = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, AluResult[WIDTH-1] ^ slt_ovf}
                                        : AluResult;
   assign exec_zero  = (op_q == OP_SLT) ? (exec_res == '0) : AluZero;
   assign exec_carry = ((op_q == OP_ADD) || (op_q == OP_SUB)) && AluCarryOut;

   always_comb begin
      state_nxt  = state;
      CmdReady   = 1'b0;
      RspValid   = 1'b0;
      AluA       = '0;
      AluB       = '0;
      AluOp      = ALUOP_AND;
      AluBNegate = 1'b0;
      case (state)
         ST_IDLE: begin
            CmdReady = 1'b1;
            if (CmdValid) begin
               if (!op_legal(CmdOp))     state_nxt = ST_RESP;
               else if (CmdOp == OP_MUL) state_nxt = ST_MUL;
               else                      state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            AluA = a_q;
            AluB = b_q;
            case (op_q)
               OP_AND:  AluOp = ALUOP_AND;
               OP_OR:   AluOp = ALUOP_OR;
               OP_ADD:  AluOp = ALUOP_ADD;
               default: begin
                  AluOp      = ALUOP_ADD;
                  AluBNegate = 1'b1;
               end
            endcase
            state_nxt = ST_RESP;
         end
         ST_MUL: begin
            AluA  = mul_a;
            AluB  = mul_b;
            AluOp = ALUOP_ADD;
            if (mul_done) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            RspValid = 1'b1;
            if (RspReady) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= ST_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         high_q  <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= CmdOp;
            a_q     <= CmdA;
            b_q     <= CmdB;
            res_q   <= '0;
            high_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= !op_legal(CmdOp);
         end else if (state == ST_EXEC) begin
            res_q   <= exec_res;
            zero_q  <= exec_zero;
            carry_q <= exec_carry;
         end else if (state == ST_MUL && mul_done) begin
            res_q  <= mul_q_nxt;
            high_q <= mul_p_nxt;
            zero_q <= (mul_q_nxt == '0);
         end
      end
   end

   assign RspResult = res_q;
   assign RspHigh   = high_q;
   assign RspZero   = zero_q;
   assign RspCarry  = carry_q;
   assign RspError  = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and reference model.
// Cycle numbering: the cycle in which a command is presented and accepted is cycle 0.
module tb_alu_sequencer;

   localparam logic [2:0] T_AND = 3'd0, T_OR = 3'd1, T_ADD = 3'd2, T_SUB = 3'd3,
                          T_SLT = 3'd4, T_MUL = 3'd5, T_BAD = 3'd6;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b1;
   logic        CmdValid = 1'b0;
   logic        CmdReady;
   logic [2:0]  CmdOp = '0;
   logic [15:0] CmdA = '0, CmdB = '0;
   logic        RspValid;
   logic        RspReady = 1'b0;
   logic [15:0] RspResult, RspHigh;
   logic        RspZero, RspCarry, RspError;
   logic [15:0] AluA, AluB, AluResult;
   logic [1:0]  AluOp;
   logic        AluBNegate, AluZero, AluCarryOut;

   int n_chk = 0;
   int n_fail = 0;

   always #5 Clock = ~Clock;

   alu_sequencer #(.WIDTH(16), .MUL_STEPS(16)) dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp), .CmdA(CmdA), .CmdB(CmdB),
      .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult), .RspHigh(RspHigh),
      .RspZero(RspZero), .RspCarry(RspCarry), .RspError(RspError),
      .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluBNegate(AluBNegate),
      .AluResult(AluResult), .AluZero(AluZero), .AluCarryOut(AluCarryOut)
   );

   // External ripple-carry ALU: B optionally inverted with carry-in set
   logic [15:0] alu_b_eff;
   logic [16:0] alu_sum;
   assign alu_b_eff = AluBNegate ? ~AluB : AluB;
   assign alu_sum   = {1'b0, AluA} + {1'b0, alu_b_eff} + {16'd0, AluBNegate};
   always_comb begin
      AluResult = '0;
      case (AluOp)
         2'b00:   AluResult = AluA & alu_b_eff;
         2'b01:   AluResult = AluA | alu_b_eff;
         default: AluResult = alu_sum[15:0];
      endcase
   end
   assign AluCarryOut = alu_sum[16];
   assign AluZero     = (AluResult == 16'd0);

   typedef struct packed {
      logic [15:0] res;
      logic [15:0] high;
      logic        zero;
      logic        carry;
      logic        err;
   } exp_t;

   function automatic exp_t ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int unsigned sum;
      logic [31:0] prod;
      e = '0;
      case (op)
         T_AND: e.res = a & b;
         T_OR:  e.res = a | b;
         T_ADD: begin
            sum     = int'(a) + int'(b);
            e.res   = sum[15:0];
            e.carry = sum[16];
         end
         T_SUB: begin
            e.res   = a - b;
            e.carry = (a >= b);
         end
         T_SLT: e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
         T_MUL: begin
            prod   = {16'd0, a} * {16'd0, b};
            e.res  = prod[15:0];
            e.high = prod[31:16];
         end
         default: e.err = 1'b1;
      endcase
      e.zero = !e.err && (e.res == 16'd0);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold);
      exp_t e;
      int   exp_lat, cyc;
      bit   got, busy_ok, stable_ok;
      logic [36:0] snap;
      e       = ref_model(op, a, b);
      exp_lat = e.err ? 1 : (op == T_MUL ? 17 : 2);
      @(negedge Clock);
      check("cmd_ready_idle", {31'd0, CmdReady}, 32'd1);
      CmdValid = 1'b1;
      CmdOp = op;
      CmdA  = a;
      CmdB  = b;
      cyc = 0; got = 0; busy_ok = 1;
      while (cyc < 40 && !got) begin
         @(negedge Clock);
         cyc++;
         CmdValid = 1'b0;
         if (RspValid) got = 1;
         else begin
            if (CmdReady || AluOp == 2'b11) busy_ok = 0;
            if (cyc == 1 && op < T_MUL) begin
               check("exec_operands", {AluA, AluB}, {a, b});
               check("exec_aluop", {29'd0, AluOp, AluBNegate},
                     {29'd0, (op == T_AND) ? 2'b00 : (op == T_OR) ? 2'b01 : 2'b10,
                      (op == T_SUB || op == T_SLT)});
            end
            // Commands offered while busy must be ignored
            CmdValid = 1'($urandom_range(0, 1));
            CmdOp = 3'($urandom);
            CmdA  = 16'($urandom);
            CmdB  = 16'($urandom);
         end
      end
      check("latency", 32'(cyc), 32'(exp_lat));
      check("busy_not_ready", {31'd0, busy_ok}, 32'd1);
      if (!got) return;
      check("rsp_result", {16'd0, RspResult}, {16'd0, e.res});
      check("rsp_high", {16'd0, RspHigh}, {16'd0, e.high});
      check("rsp_carry_err", {30'd0, RspCarry, RspError}, {30'd0, e.carry, e.err});
      if (!e.err) check("rsp_zero", {31'd0, RspZero}, {31'd0, e.zero});
      check("resp_alu_idle", {AluA, AluB}, 32'd0);
      snap = {RspResult, RspHigh, RspZero, RspCarry, RspError, RspValid, CmdReady};
      stable_ok = 1;
      for (int h = 0; h < hold; h++) begin
         CmdValid = 1'b1;
         CmdOp    = 3'($urandom);
         @(negedge Clock);
         CmdValid = 1'b0;
         if ({RspResult, RspHigh, RspZero, RspCarry, RspError, RspValid, CmdReady} !== snap)
            stable_ok = 0;
      end
      if (hold > 0) check("rsp_stable", {31'd0, stable_ok}, 32'd1);
      RspReady = 1'b1;
      @(posedge Clock);
      #1 RspReady = 1'b0;
      check("post_handshake", {30'd0, RspValid, CmdReady}, 32'd1);
   endtask

   initial begin
      logic [15:0] edge_vals [5];
      edge_vals = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};

      #2 Reset_n = 1'b0;
      repeat (2) @(negedge Clock);
      check("reset_handshake", {30'd0, CmdReady, RspValid}, 32'd2);
      check("reset_rsp", {RspResult, RspHigh}, 32'd0);
      check("reset_alu", {AluA, AluB}, 32'd0);
      check("reset_flags", {27'd0, RspZero, RspCarry, RspError, AluOp}, 32'd0);
      Reset_n = 1'b1;

      // Directed cases
      run_cmd(T_ADD, 16'h7FFF, 16'h0001, 0);
      run_cmd(T_SUB, 16'h0005, 16'h0005, 0);
      run_cmd(T_SUB, 16'h0000, 16'h0001, 0);
      run_cmd(T_SLT, 16'hFFFF, 16'h0001, 0);
      run_cmd(T_SLT, 16'h8000, 16'h7FFF, 0);
      run_cmd(T_SLT, 16'h7FFF, 16'h8000, 0);
      run_cmd(T_MUL, 16'hFFFF, 16'hFFFF, 0);
      run_cmd(T_MUL, 16'h0003, 16'h0000, 0);
      run_cmd(T_OR,  16'hA5A0, 16'h0F0F, 5);
      run_cmd(T_BAD, 16'h1234, 16'h5678, 0);
      run_cmd(3'd7,  16'hFFFF, 16'hFFFF, 2);
      run_cmd(T_AND, 16'hF0F0, 16'h3C3C, 1);

      // Randomized ops with corner operands mixed in
      for (int i = 0; i < 40; i++) begin
         logic [15:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
         run_cmd(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3));
      end

      // Asynchronous reset in the middle of a multiply
      @(negedge Clock);
      CmdValid = 1'b1; CmdOp = T_MUL; CmdA = 16'hFFFF; CmdB = 16'hFFFF;
      @(negedge Clock);
      CmdValid = 1'b0;
      repeat (7) @(negedge Clock);
      check("mul_busy_before_reset", {31'd0, CmdReady}, 32'd0);
      #2 Reset_n = 1'b0;
      #1;
      check("async_rst_handshake", {30'd0, CmdReady, RspValid}, 32'd2);
      check("async_rst_alu", {AluA, AluB}, 32'd0);
      check("async_rst_ctl", {29'd0, AluOp, AluBNegate}, 32'd0);
      check("async_rst_rsp", {RspResult, RspHigh}, 32'd0);
      check("async_rst_flags", {29'd0, RspZero, RspCarry, RspError}, 32'd0);
      @(negedge Clock);
      Reset_n = 1'b1;
      run_cmd(T_ADD, 16'h1234, 16'h1111, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Multi-cycle command front end for the CPU's 16-bit ripple-carry ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU's A, B, ALUOp and BNegate inputs.
- Captures Result/Zero/CarryOut and returns a registered response over a second valid/ready handshake.
- Builds SLT and a 16×16 unsigned multiply (shift-add, one ALU add per cycle) on top of the ALU's AND/OR/ADD primitives.

## Interface
Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- MUL_STEPS, 16, multiply iterations; must equal WIDTH.

Ports (reset is asynchronous, active-low; one clock):
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- CmdValid  in  1  command present
- CmdReady  out  1  sequencer can accept a command
- CmdOp  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 MUL, 110/111 illegal
- CmdA, CmdB  in  16  operands
- RspValid  out  1  response present
- RspReady  in  1  consumer takes the response
- RspResult  out  16  result; low half for MUL
- RspHigh  out  16  MUL upper half; 0 for all other ops
- RspZero  out  1  RspResult == 0
- RspCarry  out  1  ALU CarryOut for ADD/SUB; 0 otherwise
- RspError  out  1  illegal CmdOp
- AluA, AluB  out  16  ALU operands
- AluOp  out  2  00 AND, 01 OR, 10 ADD; 11 is never driven
- AluBNegate  out  1  invert B and set carry-in (SUB/SLT)
- AluResult  in  16  ALU result
- AluZero, AluCarryOut  in  1  ALU flags

## Operation
- States: IDLE, EXEC, MUL, RESP.
- **IDLE**
  - CmdReady=1.
  - When CmdValid=1, latch the op and operands.
  - Legal non-MUL op → EXEC. MUL → MUL. Illegal op → RESP with RspError=1 and all data fields 0.
- **EXEC** (one cycle). ALU inputs are driven from the latched registers:
  - AND/OR/ADD: AluOp=00/01/10, AluBNegate=0.
  - SUB and SLT: AluOp=10, AluBNegate=1.
  - At the clock edge, capture the result and go to RESP.
  - SLT result: {15'b0, AluResult[15] ^ ovf}, where ovf = (A[15]≠B[15]) & (AluResult[15]≠A[15]).
- **MUL** (MUL_STEPS cycles):
  - Registers: P (16-bit high accumulator, cleared on accept), Q (multiplier, loaded from CmdB), M (multiplicand, from CmdA), 5-bit step counter.
  - Each cycle: AluA=P, AluB=Q[0]?M:0, AluOp=10, AluBNegate=0.
  - At the edge: {P,Q} ← {AluCarryOut, AluResult, Q} >> 1.
  - When the counter reaches MUL_STEPS-1 → RESP, with RspHigh=P and RspResult=Q.
- **RESP**
  - RspValid=1; all Rsp* outputs are held stable until RspReady=1.
  - On the handshake edge → IDLE. A new command cannot be accepted in the same cycle.
- In IDLE and RESP: AluA=AluB=0, AluOp=00, AluBNegate=0.
- Ignored inputs:
  - CmdValid while CmdReady=0.
  - RspReady while RspValid=0.

## Timing
- Reset values:
  - state=IDLE; CmdReady=1; RspValid=0.
  - All Rsp* data outputs, Alu* outputs and internal registers are 0.
- Reset is asynchronous. Asserting it mid-EXEC, MUL or RESP drops the in-flight command with no response.
- Latency is measured from the acceptance edge k:
  - Non-MUL ops: RspValid is visible after edge k+2.
  - MUL: RspValid is visible after edge k+MUL_STEPS+1 (k+17).
  - Illegal op: RspValid is visible after edge k+1.
- Throughput: CmdReady returns to 1 one cycle after the response handshake.
  - Back-to-back ADDs therefore have a minimum spacing of 3 cycles.
- Alu* outputs are decoded from registered state and latched operands. The only combinational path is ALU round-trip → capture registers, within one cycle.

## Structure
- Package alu_seq_pkg holds:
  - CmdOp codes, AluOp codes (ALUOP_AND/OR/ADD).
  - State enum, WIDTH.
- One sub-module, alu_seq_mul_dp, holds P/Q/M, the step counter and the shift logic. It exposes ALU operand selection and a done flag.
- The ALU itself is external to this block. The top level connects the Alu* ports to it.

## Test plan
- ADD 0x7FFF+0x0001 → RspResult=0x8000, Carry=0, Zero=0; RspValid exactly 2 cycles after accept.
- SUB 0x0005−0x0005 → RspResult=0x0000, Zero=1, Carry=1; SUB 0x0000−0x0001 → 0xFFFF, Carry=0.
- SLT: 0xFFFF vs 0x0001 → 0x0001; 0x8000 vs 0x7FFF → 0x0001 (overflow path); 0x7FFF vs 0x8000 → 0x0000.
- MUL 0xFFFF×0xFFFF → RspHigh=0xFFFE, RspResult=0x0001, RspValid at k+17, CmdReady=0 throughout. MUL 0x0003×0x0000 → 0/0, Zero=1.
- Backpressure and illegal op:
  - Hold RspReady=0 for 5 cycles after an OR → outputs stable, CmdReady=0; a pulsed CmdValid is ignored.
  - CmdOp=110 → RspError=1, RspResult=0 at k+1.
- Reset and recovery: assert Reset_n=0 at MUL step 8 → all outputs reach reset values without waiting for a clock edge. After release, CmdReady=1, and ADD 0x1234+0x1111 → 0x2345.
